// File: rtl/spi_sample_rx.sv
// spi_sample_rx: SPI mode-0 slave receiver for the bridge I/Q sample stream.
// The three SPI lines are oversampled on MCU_CLK and deserialised MSB first.
// Completed bytes go into a byte FIFO, and each byte is re-emitted as two
// 4-bit samples (high nibble first) over a valid/ready handshake.
// Optional build macro SPI_SAMPLE_RX_SELF_TEST_CHECK_EN adds a checker that
// compares accepted samples with the incrementing self-test nibble pattern.

module spi_sample_rx #(
   parameter int FIFO_DEPTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic        MCU_CLK,
   input  logic        RESET_P,
   input  logic        MCU_SCK,
   input  logic        MCU_SS,
   input  logic        MCU_MOSI,
   output logic [3:0]  SAMPLE,
   output logic        SAMPLE_VALID,
   input  logic        SAMPLE_READY,
   output logic        FRAME_ERR,
   output logic        OVERFLOW,
   output logic [15:0] ERR_COUNT
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] ss_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sck_hist;
   logic                   sck_s;
   logic                   ss_s;
   logic                   mosi_s;
   logic                   sck_rise;

   state_t     state;
   state_t     next_state;
   logic [2:0] bit_cnt;
   logic [6:0] shreg;
   logic [7:0] shift_data;
   logic       shift_en;
   logic       byte_done;
   logic       frame_err_set;

   logic [7:0] mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] vis_ptr;
   logic [AW:0] rd_next;
   logic        full;
   logic        wr_en;
   logic        drop;
   logic        avail;
   logic        next_avail;
   logic [7:0]  head;
   logic [7:0]  next_head;

   logic       phase;
   logic       accept;
   logic       pop;
   logic [3:0] sample_n;
   logic       valid_n;
   logic       phase_n;

   // Synchronise the asynchronous SPI lines and keep one SCK history flop for edge detection
   always_ff @(posedge MCU_CLK or posedge RESET_P) begin
      if (RESET_P) begin
         sck_sync  <= '0;
         ss_sync   <= '1;
         mosi_sync <= '0;
         sck_hist  <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], MCU_SCK};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], MCU_SS};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MCU_MOSI};
         sck_hist  <= sck_sync[SYNC_STAGES-1];
      end
   end

   assign sck_s      = sck_sync[SYNC_STAGES-1];
   assign ss_s       = ss_sync[SYNC_STAGES-1];
   assign mosi_s     = mosi_sync[SYNC_STAGES-1];
   assign sck_rise   = sck_s & ~sck_hist;
   assign shift_data = {shreg, mosi_s};

   // Frame FSM state register
   always_ff @(posedge MCU_CLK or posedge RESET_P) begin
      if (RESET_P) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Frame FSM next state; SS deassertion wins over a coincident SCK edge
   always_comb begin
      next_state    = state;
      shift_en      = 1'b0;
      frame_err_set = 1'b0;
      case (state)
         IDLE: begin
            if (!ss_s) begin
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            if (ss_s) begin
               next_state    = IDLE;
               frame_err_set = (bit_cnt != 3'd0);
            end else if (sck_rise) begin
               shift_en = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign byte_done = shift_en && (bit_cnt == 3'd7);

   // Bit counter and shift register; the counter is cleared outside an active frame
   always_ff @(posedge MCU_CLK or posedge RESET_P) begin
      if (RESET_P) begin
         bit_cnt   <= 3'd0;
         shreg     <= 7'd0;
         FRAME_ERR <= 1'b0;
      end else begin
         FRAME_ERR <= frame_err_set;
         if (state != SHIFT || ss_s) begin
            bit_cnt <= 3'd0;
         end else if (shift_en) begin
            bit_cnt <= bit_cnt + 3'd1;
            shreg   <= shift_data[6:0];
         end
      end
   end

   // FIFO status; a write is allowed when full if the head is popped in the same cycle
   assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign wr_en      = byte_done && (!full || pop);
   assign drop       = byte_done && full && !pop;
   assign rd_next    = rd_ptr + PTR_ONE;
   assign avail      = (rd_ptr != vis_ptr);
   assign next_avail = (rd_next != vis_ptr);
   assign head       = mem[rd_ptr[AW-1:0]];
   assign next_head  = mem[rd_next[AW-1:0]];

   // FIFO storage array
   always_ff @(posedge MCU_CLK) begin
      if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= shift_data;
      end
   end

   // FIFO pointers; the reader sees a write one cycle late through vis_ptr
   always_ff @(posedge MCU_CLK or posedge RESET_P) begin
      if (RESET_P) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         vis_ptr  <= '0;
         OVERFLOW <= 1'b0;
      end else begin
         vis_ptr <= wr_ptr;
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_next;
         end
         if (drop) begin
            OVERFLOW <= 1'b1;
         end
      end
   end

   assign accept = SAMPLE_VALID && SAMPLE_READY;
   assign pop    = accept && phase;

   // Nibble unpacker: the head byte stays in the FIFO until its low nibble is accepted
   always_comb begin
      sample_n = SAMPLE;
      valid_n  = SAMPLE_VALID;
      phase_n  = phase;
      if (!SAMPLE_VALID) begin
         if (avail) begin
            sample_n = head[7:4];
            valid_n  = 1'b1;
            phase_n  = 1'b0;
         end
      end else if (accept) begin
         if (!phase) begin
            sample_n = head[3:0];
            phase_n  = 1'b1;
         end else if (next_avail) begin
            sample_n = next_head[7:4];
            valid_n  = 1'b1;
            phase_n  = 1'b0;
         end else begin
            sample_n = 4'd0;
            valid_n  = 1'b0;
            phase_n  = 1'b0;
         end
      end
   end

   // Registered sample output
   always_ff @(posedge MCU_CLK or posedge RESET_P) begin
      if (RESET_P) begin
         SAMPLE       <= 4'd0;
         SAMPLE_VALID <= 1'b0;
         phase        <= 1'b0;
      end else begin
         SAMPLE       <= sample_n;
         SAMPLE_VALID <= valid_n;
         phase        <= phase_n;
      end
   end

`ifdef SPI_SAMPLE_RX_SELF_TEST_CHECK_EN
   logic [3:0]  ref_nib;
   logic        seeded;
   logic [15:0] err_cnt;

   // Self-test checker: first accepted sample seeds, later ones must follow by +1
   always_ff @(posedge MCU_CLK or posedge RESET_P) begin
      if (RESET_P) begin
         ref_nib <= 4'd0;
         seeded  <= 1'b0;
         err_cnt <= 16'd0;
      end else if (accept) begin
         seeded  <= 1'b1;
         ref_nib <= SAMPLE;
         if (seeded && (SAMPLE != ref_nib + 4'd1) && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
         end
      end
   end

   assign ERR_COUNT = err_cnt;
`else
   assign ERR_COUNT = 16'd0;
`endif

endmodule

// File: tb/tb_spi_sample_rx.sv
// tb_spi_sample_rx: directed bench for spi_sample_rx driving SPI mode 0 at MCU_CLK/4.

module tb_spi_sample_rx;

   logic        MCU_CLK = 1'b0;
   logic        RESET_P;
   logic        MCU_SCK;
   logic        MCU_SS;
   logic        MCU_MOSI;
   logic [3:0]  SAMPLE;
   logic        SAMPLE_VALID;
   logic        SAMPLE_READY;
   logic        FRAME_ERR;
   logic        OVERFLOW;
   logic [15:0] ERR_COUNT;

   int         n_vec = 0;
   int         n_err = 0;
   int         fe_cnt = 0;
   int         valid_cycles = 0;
   int         lat;
   logic [3:0] got_q[$];

`ifdef SPI_SAMPLE_RX_SELF_TEST_CHECK_EN
   localparam int EXP_ERR = 1;
`else
   localparam int EXP_ERR = 0;
`endif

   spi_sample_rx #(
      .FIFO_DEPTH(16),
      .SYNC_STAGES(2)
   ) dut (
      .MCU_CLK(MCU_CLK),
      .RESET_P(RESET_P),
      .MCU_SCK(MCU_SCK),
      .MCU_SS(MCU_SS),
      .MCU_MOSI(MCU_MOSI),
      .SAMPLE(SAMPLE),
      .SAMPLE_VALID(SAMPLE_VALID),
      .SAMPLE_READY(SAMPLE_READY),
      .FRAME_ERR(FRAME_ERR),
      .OVERFLOW(OVERFLOW),
      .ERR_COUNT(ERR_COUNT)
   );

   // 100 MHz system clock
   always #5 MCU_CLK = ~MCU_CLK;

   // Record accepted samples, FRAME_ERR cycles and VALID cycles mid-cycle
   always @(negedge MCU_CLK) begin
      if (!RESET_P) begin
         if (SAMPLE_VALID && SAMPLE_READY) got_q.push_back(SAMPLE);
         if (FRAME_ERR) fe_cnt++;
         if (SAMPLE_VALID) valid_cycles++;
      end
   end

   // Guard against a hung run
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic waitClk(input int n);
      repeat (n) begin
         @(posedge MCU_CLK);
         #1;
      end
   endtask

   // Shift out the top nbits of data, MSB first, SCK period of four MCU_CLK cycles
   task automatic applyStimulus(input logic [7:0] data, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) begin
         MCU_MOSI = data[i];
         waitClk(2);
         MCU_SCK = 1'b1;
         waitClk(2);
         MCU_SCK = 1'b0;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pick(input int k);
      if (k < got_q.size()) return 32'(got_q[k]);
      return 32'hDEAD;
   endfunction

   task automatic clearLog();
      got_q.delete();
      fe_cnt = 0;
      valid_cycles = 0;
   endtask

   initial begin
      RESET_P = 1'b1;
      MCU_SCK = 1'b0;
      MCU_SS = 1'b1;
      MCU_MOSI = 1'b0;
      SAMPLE_READY = 1'b1;
      waitClk(3);
      RESET_P = 1'b0;
      waitClk(2);

      $display("[TB] reset state");
      checkOutput("rst_sample", 32'(SAMPLE), 32'h0);
      checkOutput("rst_valid", 32'(SAMPLE_VALID), 32'h0);
      checkOutput("rst_frame_err", 32'(FRAME_ERR), 32'h0);
      checkOutput("rst_overflow", 32'(OVERFLOW), 32'h0);
      checkOutput("rst_err_count", 32'(ERR_COUNT), 32'h0);

      $display("[TB] single byte 0xA5");
      clearLog();
      MCU_SS = 1'b0;
      waitClk(4);
      applyStimulus(8'hA5, 8);
      waitClk(2);
      MCU_SS = 1'b1;
      waitClk(20);
      checkOutput("a5_count", 32'(got_q.size()), 32'd2);
      checkOutput("a5_s0", pick(0), 32'hA);
      checkOutput("a5_s1", pick(1), 32'h5);
      checkOutput("a5_valid_cycles", 32'(valid_cycles), 32'd2);
      checkOutput("a5_frame_err", 32'(fe_cnt), 32'd0);

      $display("[TB] latency with byte 0x96");
      clearLog();
      MCU_SS = 1'b0;
      waitClk(4);
      applyStimulus(8'h96, 7);
      MCU_MOSI = 1'b0;
      waitClk(2);
      MCU_SCK = 1'b1;
      lat = 0;
      while (SAMPLE_VALID !== 1'b1 && lat < 20) begin
         waitClk(1);
         lat++;
      end
      checkOutput("lat_edges", 32'(lat), 32'd5);
      checkOutput("lat_first_sample", 32'(SAMPLE), 32'h9);
      MCU_SCK = 1'b0;
      waitClk(2);
      MCU_SS = 1'b1;
      waitClk(10);
      checkOutput("lat_count", 32'(got_q.size()), 32'd2);
      checkOutput("lat_s1", pick(1), 32'h6);

      $display("[TB] partial byte then 0x3C");
      clearLog();
      MCU_SS = 1'b0;
      waitClk(4);
      applyStimulus(8'hE8, 5);
      waitClk(2);
      MCU_SS = 1'b1;
      waitClk(10);
      checkOutput("part_frame_err", 32'(fe_cnt), 32'd1);
      checkOutput("part_no_sample", 32'(got_q.size()), 32'd0);
      MCU_SS = 1'b0;
      waitClk(4);
      applyStimulus(8'h3C, 8);
      waitClk(2);
      MCU_SS = 1'b1;
      waitClk(20);
      checkOutput("3c_count", 32'(got_q.size()), 32'd2);
      checkOutput("3c_s0", pick(0), 32'h3);
      checkOutput("3c_s1", pick(1), 32'hC);
      checkOutput("3c_frame_err", 32'(fe_cnt), 32'd1);

      $display("[TB] backpressure and overflow");
      clearLog();
      SAMPLE_READY = 1'b0;
      MCU_SS = 1'b0;
      waitClk(4);
      for (int b = 0; b < 17; b++) begin
         applyStimulus(8'(b), 8);
      end
      waitClk(2);
      MCU_SS = 1'b1;
      waitClk(10);
      checkOutput("ovf_flag", 32'(OVERFLOW), 32'h1);
      checkOutput("ovf_valid_held", 32'(SAMPLE_VALID), 32'h1);
      checkOutput("ovf_sample_held", 32'(SAMPLE), 32'h0);
      checkOutput("ovf_none_taken", 32'(got_q.size()), 32'd0);
      SAMPLE_READY = 1'b1;
      waitClk(80);
      checkOutput("ovf_drain_count", 32'(got_q.size()), 32'd32);
      for (int k = 0; k < 32; k++) begin
         checkOutput($sformatf("ovf_s%0d", k), pick(k), 32'((k % 2 == 0) ? 0 : k / 2));
      end
      checkOutput("ovf_sticky", 32'(OVERFLOW), 32'h1);
      checkOutput("ovf_frame_err", 32'(fe_cnt), 32'd0);

      $display("[TB] reset mid-frame then 0x81");
      clearLog();
      MCU_SS = 1'b0;
      waitClk(4);
      applyStimulus(8'hF0, 4);
      RESET_P = 1'b1;
      waitClk(2);
      checkOutput("mid_rst_overflow", 32'(OVERFLOW), 32'h0);
      checkOutput("mid_rst_valid", 32'(SAMPLE_VALID), 32'h0);
      RESET_P = 1'b0;
      waitClk(4);
      applyStimulus(8'h81, 8);
      waitClk(2);
      MCU_SS = 1'b1;
      waitClk(20);
      checkOutput("81_count", 32'(got_q.size()), 32'd2);
      checkOutput("81_s0", pick(0), 32'h8);
      checkOutput("81_s1", pick(1), 32'h1);
      checkOutput("81_frame_err", 32'(fe_cnt), 32'd0);
      checkOutput("81_overflow", 32'(OVERFLOW), 32'h0);

      $display("[TB] self-test pattern stream");
      RESET_P = 1'b1;
      waitClk(2);
      RESET_P = 1'b0;
      waitClk(4);
      clearLog();
      MCU_SS = 1'b0;
      waitClk(4);
      applyStimulus(8'h01, 8);
      applyStimulus(8'h23, 8);
      applyStimulus(8'h45, 8);
      applyStimulus(8'h67, 8);
      applyStimulus(8'h89, 8);
      applyStimulus(8'hAB, 8);
      applyStimulus(8'hCD, 8);
      applyStimulus(8'hEF, 8);
      applyStimulus(8'h01, 8);
      waitClk(2);
      MCU_SS = 1'b1;
      waitClk(20);
      checkOutput("st_clean_count", 32'(got_q.size()), 32'd18);
      checkOutput("st_clean_err", 32'(ERR_COUNT), 32'd0);
      MCU_SS = 1'b0;
      waitClk(4);
      applyStimulus(8'h23, 8);
      applyStimulus(8'h45, 8);
      applyStimulus(8'h69, 8);
      applyStimulus(8'hAB, 8);
      waitClk(2);
      MCU_SS = 1'b1;
      waitClk(20);
      checkOutput("st_bad_count", 32'(got_q.size()), 32'd26);
      checkOutput("st_bad_nibble", pick(23), 32'h9);
      checkOutput("st_bad_err", 32'(ERR_COUNT), 32'(EXP_ERR));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
